// File: rtl/piso_bit_feeder.sv
// Parallel-in/serial-out feeder for the 1011 sequence detector's serial input.
// Accepts WIDTH-bit words over valid/ready and emits one bit per clock; back-to-back
// words stream without a bubble, and the line rests at IDLE_LEVEL between words.
module piso_bit_feeder #(
    parameter int unsigned WIDTH      = 8,
    parameter bit          MSB_FIRST  = 1'b1,
    parameter bit          IDLE_LEVEL = 1'b0
) (
    input  logic             clk,
    input  logic             reset,      // active-low, asynchronous
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    input  logic             abort,
    output logic             x,
    output logic             x_valid,
    output logic             word_done
);

    localparam int unsigned CntW = $clog2(WIDTH);
    localparam logic [CntW-1:0] LastIdx = CntW'(WIDTH - 1);

    typedef enum logic [0:0] {StIdle, StShift} state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   sreg_q, sreg_d;
    logic [CntW-1:0]    cnt_q, cnt_d;
    logic               last;
    logic               accept;
    logic [WIDTH-1:0]   sreg_shifted;

    // Decode the last-bit cycle and the handshake.
    always_comb begin
        last      = (state_q == StShift) && (cnt_q == LastIdx);
        din_ready = reset && !abort && ((state_q == StIdle) || last);
        accept    = din_valid && din_ready;
    end

    // Move the next bit toward whichever end feeds x, filling with zeros.
    always_comb begin
        if (MSB_FIRST) begin
            sreg_shifted = {sreg_q[WIDTH-2:0], 1'b0};
        end else begin
            sreg_shifted = {1'b0, sreg_q[WIDTH-1:1]};
        end
    end

    // Next-state logic; abort outranks a reload in the same cycle.
    always_comb begin
        state_d = state_q;
        sreg_d  = sreg_q;
        cnt_d   = cnt_q;
        if (abort) begin
            state_d = StIdle;
            cnt_d   = '0;
        end else if (accept) begin
            state_d = StShift;
            sreg_d  = din;
            cnt_d   = '0;
        end else if (state_q == StShift) begin
            if (last) begin
                state_d = StIdle;
                cnt_d   = '0;
            end else begin
                sreg_d = sreg_shifted;
                cnt_d  = cnt_q + CntW'(1);
            end
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            sreg_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sreg_q  <= sreg_d;
            cnt_q   <= cnt_d;
        end
    end

    // Serial outputs; state is cleared asynchronously so these drop with reset.
    always_comb begin
        x_valid   = (state_q == StShift);
        word_done = last;
        if (x_valid) begin
            x = MSB_FIRST ? sreg_q[WIDTH-1] : sreg_q[0];
        end else begin
            x = IDLE_LEVEL;
        end
    end

endmodule

// File: tb/tb_piso_bit_feeder.sv
// Bench for piso_bit_feeder: an MSB-first and an LSB-first instance share one stimulus
// stream and are checked every cycle against a queue-of-bits reference model.
module tb_piso_bit_feeder;

    localparam int unsigned W = 8;

    logic         clk = 1'b0;
    logic         reset;
    logic [W-1:0] din;
    logic         din_valid;
    logic         abort;

    logic xm, xm_valid, m_done, m_ready;
    logic xl, xl_valid, l_done, l_ready;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: bits still to be shown for the current word, head = on the line now.
    bit qm[$];
    bit ql[$];

    logic samp_xm, samp_xl, samp_vm;
    bit   last_accept;

    always #5 clk = ~clk;

    piso_bit_feeder #(.WIDTH(W), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) dut_m (
        .clk       (clk),
        .reset     (reset),
        .din       (din),
        .din_valid (din_valid),
        .din_ready (m_ready),
        .abort     (abort),
        .x         (xm),
        .x_valid   (xm_valid),
        .word_done (m_done)
    );

    piso_bit_feeder #(.WIDTH(W), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b0)) dut_l (
        .clk       (clk),
        .reset     (reset),
        .din       (din),
        .din_valid (din_valid),
        .din_ready (l_ready),
        .abort     (abort),
        .x         (xl),
        .x_valid   (xl_valid),
        .word_done (l_done)
    );

    task automatic check(input string tag, input logic got, input logic exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%b expected=%b at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_vec(input string tag, input logic [W-1:0] got,
                             input logic [W-1:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit exp_ready();
        return reset && !abort && (qm.size() <= 1);
    endfunction

    // One clock: compare all outputs on the falling edge, then advance the model on the rising edge.
    task automatic tick();
        bit acc;
        @(negedge clk);
        samp_xm = xm;
        samp_xl = xl;
        samp_vm = xm_valid;
        check("m_x_valid", xm_valid, qm.size() != 0);
        check("m_x",       xm,       (qm.size() != 0) ? qm[0] : 1'b0);
        check("m_done",    m_done,   qm.size() == 1);
        check("m_ready",   m_ready,  exp_ready());
        check("l_x_valid", xl_valid, ql.size() != 0);
        check("l_x",       xl,       (ql.size() != 0) ? ql[0] : 1'b0);
        check("l_done",    l_done,   ql.size() == 1);
        check("l_ready",   l_ready,  exp_ready());
        acc = din_valid && exp_ready();
        @(posedge clk);
        if (!reset || abort) begin
            qm.delete();
            ql.delete();
        end else if (acc) begin
            qm.delete();
            ql.delete();
            for (int i = 0; i < W; i++) begin
                qm.push_back(din[W-1-i]);
                ql.push_back(din[i]);
            end
        end else if (qm.size() != 0) begin
            void'(qm.pop_front());
            void'(ql.pop_front());
        end
        last_accept = acc;
        #1;
    endtask

    initial begin
        logic [W-1:0] obs_m;
        logic [W-1:0] obs_l;
        int           run;
        int           gap;

        reset     = 1'b0;
        din       = '0;
        din_valid = 1'b0;
        abort     = 1'b0;

        // Held in reset: outputs quiet, not ready.
        repeat (3) tick();
        reset = 1'b1;

        // 1: idle line for 20 cycles.
        repeat (20) tick();

        // 2: single word 8'hB4, bits captured from both instances.
        din = 8'hB4; din_valid = 1'b1;
        tick();
        din_valid = 1'b0;
        obs_m = '0; obs_l = '0; run = 0;
        for (int i = 0; i < W; i++) begin
            tick();
            obs_m = {obs_m[W-2:0], samp_xm};
            obs_l = {obs_l[W-2:0], samp_xl};
            if (samp_vm) run++;
        end
        check_vec("b4_msb_bits", obs_m, 8'hB4);
        check_vec("b4_lsb_bits", obs_l, 8'h2D);
        check_vec("b4_valid_cnt", W'(run), W'(8));
        tick();
        check("b4_valid_after", samp_vm, 1'b0);

        // 3: back-to-back 8'hB4 then 8'h0B with valid held; count contiguous valid bits.
        din = 8'hB4; din_valid = 1'b1;
        tick();
        din = 8'h0B;
        run = 0; gap = 0;
        for (int i = 0; i < 2 * W + 2; i++) begin
            if (last_accept && din == 8'h0B && i > 0) din_valid = 1'b0;
            tick();
            if (samp_vm) begin
                run++;
                if (gap != 0 && run > 1) gap = 99;
            end else if (run != 0) begin
                gap++;
            end
        end
        check_vec("b2b_valid_run", W'(run), W'(16));
        din_valid = 1'b0;
        repeat (2) tick();

        // 4: 8'h0D least-significant bit first.
        din = 8'h0D; din_valid = 1'b1;
        tick();
        din_valid = 1'b0;
        obs_l = '0;
        for (int i = 0; i < W; i++) begin
            tick();
            obs_l = {obs_l[W-2:0], samp_xl};
        end
        check_vec("0d_lsb_bits", obs_l, 8'hB0);
        tick();

        // 5: abort during the 3rd bit with a new word offered.
        din = 8'hFF; din_valid = 1'b1;
        tick();
        din = 8'hA5;
        repeat (2) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0; din_valid = 1'b0;
        tick();
        check("abort_idle_valid", samp_vm, 1'b0);
        check("abort_idle_x", samp_xm, 1'b0);
        tick();

        // 6: asynchronous reset mid-word, then a fresh word.
        din = 8'hC3; din_valid = 1'b1;
        tick();
        din_valid = 1'b0;
        repeat (3) tick();
        reset = 1'b0;
        #2;
        check("async_m_valid", xm_valid, 1'b0);
        check("async_m_ready", m_ready, 1'b0);
        check("async_l_valid", xl_valid, 1'b0);
        qm.delete(); ql.delete();
        repeat (2) tick();
        reset = 1'b1;
        tick();
        din = 8'h96; din_valid = 1'b1;
        tick();
        din_valid = 1'b0;
        obs_m = '0;
        for (int i = 0; i < W; i++) begin
            tick();
            obs_m = {obs_m[W-2:0], samp_xm};
        end
        check_vec("post_reset_bits", obs_m, 8'h96);
        tick();

        // Random traffic with occasional aborts; din held while offered and not taken.
        for (int c = 0; c < 600; c++) begin
            if (din_valid && last_accept) din_valid = 1'b0;
            if (!din_valid && ($urandom_range(0, 9) < 7)) begin
                din_valid = 1'b1;
                din = W'($urandom);
            end
            abort = ($urandom_range(0, 19) == 0);
            tick();
        end
        abort = 1'b0; din_valid = 1'b0;
        repeat (W + 2) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
